post_adder_preg: RTL and testbench
==================================

POST_ADDER_PREG -- requirements
Module: post_adder_preg

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PREG, 1, 1 = P and CARRYOUT registered; 0 = combinational bypass.
- CARRYINREG, 1, 1 = selected carry-in registered; 0 = bypass.
- OPMODEREG, 1, 1 = OPMODE registered; 0 = bypass.
- CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" selects opmode bit 5; "CARRYIN" selects port CARRYIN.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, in, 1, single clock, rising edge.
- RSTP, in, 1, P/CARRYOUT reset; asynchronous, active-high.
- RSTCARRYIN, in, 1, carry-in register reset; asynchronous, active-high.
- RSTOPMODE, in, 1, OPMODE register reset; asynchronous, active-high.
- CEP / CECARRYIN / CEOPMODE, in, 1 each, clock enables for the three register groups.
- OPMODE, in, 8, operation control.
- M, in, 36, multiplier product.
- DAB, in, 48, concatenated {D[11:0],A,B} operand.
- C, in, 48, C operand.
- PCIN, in, 48, cascade input from the previous slice.
- CARRYIN, in, 1, external carry-in.
- P / PCOUT, out, 48 each, result; PCOUT identical to P.
- CARRYOUT / CARRYOUTF, out, 1 each, carry/borrow; CARRYOUTF identical to CARRYOUT.

Function
REQ-003 The effective opmode (op) SHALL be the OPMODE register output when OPMODEREG=1, else the OPMODE port.
REQ-004 The X mux SHALL be driven by op[1:0]: 0 -> 0; 1 -> M zero-extended to 48 bits; 2 -> P (feedback); 3 -> DAB.
REQ-005 The Z mux SHALL be driven by op[3:2]: 0 -> 0; 1 -> PCIN; 2 -> P; 3 -> C.
REQ-006 The carry-in source SHALL be op[5] or CARRYIN, per CARRYINSEL. CIN is the CYI register output when CARRYINREG=1, else the source directly.
REQ-007 When op[7]=0, the 49-bit result SHALL be {0,Z} + {0,X} + CIN.
REQ-008 When op[7]=1, the 49-bit result SHALL be {0,Z} - ({0,X} + CIN).
REQ-009 P SHALL equal result[47:0] and CARRYOUT SHALL equal result[48]. All arithmetic wraps modulo 2^48; there is no saturation.
REQ-010 With PREG=1, P and CARRYOUT SHALL update on the CLK edge where CEP=1, and hold when CEP=0. Latency is 1 cycle from the mux inputs.
REQ-011 With PREG=0, P and CARRYOUT SHALL be combinational, and op[1:0]=2 or op[3:2]=2 is unsupported (combinational loop). The bench shall not drive these codes in that configuration.
REQ-012 Feedback SHALL use registered P, so accumulation (op[3:2]=2) adds X once per enabled cycle.
REQ-013 When CEOPMODE=0, OPMODE changes SHALL take effect only after the next enabled edge.
REQ-014 op bits 4 and 6 SHALL be ignored by this block (they are pre-adder controls).

Reset
REQ-015 RSTP=1 SHALL clear P and CARRYOUT to 0 immediately, independent of CLK and CEP.
REQ-016 RSTCARRYIN SHALL clear the CYI register to 0, and RSTOPMODE SHALL clear the OPMODE register to 8'h00 (X=0, Z=0, add), immediately.
REQ-017 Reset SHALL take priority over CE. On the first CLK edge after deassertion, normal capture SHALL resume. Asserting reset mid-accumulation SHALL restart accumulation from 0.
REQ-018 A reset to a register whose bypass is selected SHALL have no effect on outputs.

Structure
REQ-019 The shared package (dsp48a1_pkg) SHALL hold: the width constants (48, 36, 18), the X/Z select encodings, and the CARRYINSEL string constants.
REQ-020 One sub-module is natural: dsp_pipe_reg, a parameterised-width register with CE, asynchronous active-high reset and a bypass parameter. It SHALL be instantiated for OPMODE (8), CYI (1) and P+CARRYOUT (49).

Verification
REQ-021 The bench SHALL cover the following directed scenarios, each as stimulus -> required response.
- Add: OPMODE=8'h0D (X=M, Z=C), M=36'd5, C=48'd7, CARRYINSEL="CARRYIN", CARRYIN=1 -> P=13 and CARRYOUT=0, one cycle after op is effective.
- Subtract: OPMODE=8'h8D, M=5, C=7, CIN=0 -> P=2; then C=3 -> P=48'hFFFF_FFFF_FFFE with CARRYOUT=1.
- Accumulate: OPMODE=8'h09 (X=M, Z=P), M=3 for 4 enabled cycles from P=0 -> P=3,6,9,12; CEP=0 for 2 cycles -> P holds at 12.
- Wrap: Z=C=48'hFFFF_FFFF_FFFF, X=DAB=1, add -> P=0 and CARRYOUT=1.
- Asynchronous reset: RSTP pulsed between clock edges during accumulation at P=9 -> P=0 before the next edge; accumulation resumes at 3.
- Bypass: PREG=0 and OPMODEREG=0, OPMODE=8'h0F with DAB=10, C=20 -> P=30 in the same cycle; RSTP has no effect.

Source files
------------

// File: rtl/dsp48a1_pkg.sv
// Shared constants, select encodings and post-adder arithmetic for the DSP48A1-style slice.
package dsp48a1_pkg;

    localparam int unsigned PWidth  = 48;
    localparam int unsigned MWidth  = 36;
    localparam int unsigned BWidth  = 18;
    localparam int unsigned DWidth  = PWidth - 2 * BWidth;
    localparam int unsigned OpWidth = 8;

    typedef enum logic [1:0] {
        XSelZero = 2'd0,
        XSelM    = 2'd1,
        XSelP    = 2'd2,
        XSelDab  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        ZSelZero = 2'd0,
        ZSelPcin = 2'd1,
        ZSelP    = 2'd2,
        ZSelC    = 2'd3
    } z_sel_e;

    localparam string CarryinSelOpmode5 = "OPMODE5";
    localparam string CarryinSelCarryin = "CARRYIN";

    // Bits 4 and 6 belong to the pre-adder and are carried here only to keep the layout.
    typedef struct packed {
        logic   post_sub;
        logic   pre_bit6;
        logic   carry;
        logic   pre_bit4;
        z_sel_e z_sel;
        x_sel_e x_sel;
    } op_t;

    // Returns {carry/borrow, sum}; subtraction is Z - (X + CIN).
    function automatic logic [PWidth:0] post_add(
        input logic [PWidth-1:0] z,
        input logic [PWidth-1:0] x,
        input logic              cin,
        input logic              sub
    );
        logic [PWidth:0] xc;
        xc = {1'b0, x} + {{PWidth{1'b0}}, cin};
        if (sub) begin
            return {1'b0, z} - xc;
        end
        return {1'b0, z} + xc;
    endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register with clock enable and asynchronous active-high reset.
module dsp_pipe_reg #(
    parameter int unsigned Width  = 1,
    parameter bit          Bypass = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    if (Bypass) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, ce};
        assign q = d;
    end else begin : g_reg
        logic [Width-1:0] state;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= '0;
            end else if (ce) begin
                state <= d;
            end
        end
        assign q = state;
    end

endmodule

// File: rtl/post_adder_preg.sv
// Post-adder/subtracter with X/Z operand muxes, selectable carry-in and optional P register.
module post_adder_preg
    import dsp48a1_pkg::*;
#(
    parameter int unsigned PREG       = 1,
    parameter int unsigned CARRYINREG = 1,
    parameter int unsigned OPMODEREG  = 1,
    parameter string       CARRYINSEL = "OPMODE5"
) (
    input  logic                         CLK,
    input  logic                         RSTP,
    input  logic                         RSTCARRYIN,
    input  logic                         RSTOPMODE,
    input  logic                         CEP,
    input  logic                         CECARRYIN,
    input  logic                         CEOPMODE,
    input  logic [OpWidth-1:0]           OPMODE,
    input  logic [MWidth-1:0]            M,
    input  logic [DWidth+2*BWidth-1:0]   DAB,
    input  logic [PWidth-1:0]            C,
    input  logic [PWidth-1:0]            PCIN,
    input  logic                         CARRYIN,
    output logic [PWidth-1:0]            P,
    output logic [PWidth-1:0]            PCOUT,
    output logic                         CARRYOUT,
    output logic                         CARRYOUTF
);

    logic [OpWidth-1:0] op_raw;
    op_t                op;
    logic               cyi_src;
    logic               cin;
    logic [PWidth-1:0]  p_fb;
    logic [PWidth-1:0]  x_mux;
    logic [PWidth-1:0]  z_mux;
    logic [PWidth:0]    result;
    logic [PWidth:0]    p_out;
    logic               unused_bits;

    dsp_pipe_reg #(
        .Width  (OpWidth),
        .Bypass (OPMODEREG == 0)
    ) u_opmode_reg (
        .clk (CLK),
        .rst (RSTOPMODE),
        .ce  (CEOPMODE),
        .d   (OPMODE),
        .q   (op_raw)
    );

    assign op = op_t'(op_raw);

    if (CARRYINSEL == CarryinSelCarryin) begin : g_cin_port
        assign cyi_src = CARRYIN;
    end else begin : g_cin_opmode
        assign cyi_src = op.carry;
    end

    dsp_pipe_reg #(
        .Width  (1),
        .Bypass (CARRYINREG == 0)
    ) u_cyi_reg (
        .clk (CLK),
        .rst (RSTCARRYIN),
        .ce  (CECARRYIN),
        .d   (cyi_src),
        .q   (cin)
    );

    // Without a P register the feedback path would be a combinational loop; tie it off.
    if (PREG != 0) begin : g_fb_reg
        assign p_fb = p_out[PWidth-1:0];
    end else begin : g_fb_none
        assign p_fb = '0;
    end

    always_comb begin
        x_mux = '0;
        unique case (op.x_sel)
            XSelZero: x_mux = '0;
            XSelM:    x_mux = {{(PWidth - MWidth){1'b0}}, M};
            XSelP:    x_mux = p_fb;
            XSelDab:  x_mux = DAB;
            default:  x_mux = '0;
        endcase
    end

    always_comb begin
        z_mux = '0;
        unique case (op.z_sel)
            ZSelZero: z_mux = '0;
            ZSelPcin: z_mux = PCIN;
            ZSelP:    z_mux = p_fb;
            ZSelC:    z_mux = C;
            default:  z_mux = '0;
        endcase
    end

    assign result = post_add(z_mux, x_mux, cin, op.post_sub);

    dsp_pipe_reg #(
        .Width  (PWidth + 1),
        .Bypass (PREG == 0)
    ) u_p_reg (
        .clk (CLK),
        .rst (RSTP),
        .ce  (CEP),
        .d   (result),
        .q   (p_out)
    );

    assign P         = p_out[PWidth-1:0];
    assign PCOUT     = p_out[PWidth-1:0];
    assign CARRYOUT  = p_out[PWidth];
    assign CARRYOUTF = p_out[PWidth];

    assign unused_bits = ^{op.pre_bit4, op.pre_bit6, op.carry, CARRYIN};

endmodule

// File: tb/tb_post_adder_preg.sv
// Self-checking bench for post_adder_preg: directed scenarios plus randomized traffic vs a model.
module tb_post_adder_preg;

    logic        clk = 1'b0;
    logic        rstp, rstcarryin, rstopmode;
    logic        cep, cecarryin, ceopmode;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [47:0] dab, c, pcin;
    logic        carryin;
    logic [47:0] p, pcout, b_p, b_pcout;
    logic        carryout, carryoutf, b_co, b_cof;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state of the registered instance.
    logic [7:0]  m_op;
    logic        m_cyi;
    logic [47:0] m_p;
    logic        m_co;

    always #5 clk = ~clk;

    post_adder_preg #(
        .PREG       (1),
        .CARRYINREG (1),
        .OPMODEREG  (1),
        .CARRYINSEL ("CARRYIN")
    ) u_dut (
        .CLK (clk), .RSTP (rstp), .RSTCARRYIN (rstcarryin), .RSTOPMODE (rstopmode),
        .CEP (cep), .CECARRYIN (cecarryin), .CEOPMODE (ceopmode), .OPMODE (opmode),
        .M (m), .DAB (dab), .C (c), .PCIN (pcin), .CARRYIN (carryin),
        .P (p), .PCOUT (pcout), .CARRYOUT (carryout), .CARRYOUTF (carryoutf)
    );

    post_adder_preg #(
        .PREG       (0),
        .CARRYINREG (0),
        .OPMODEREG  (0),
        .CARRYINSEL ("OPMODE5")
    ) u_byp (
        .CLK (clk), .RSTP (rstp), .RSTCARRYIN (rstcarryin), .RSTOPMODE (rstopmode),
        .CEP (cep), .CECARRYIN (cecarryin), .CEOPMODE (ceopmode), .OPMODE (opmode),
        .M (m), .DAB (dab), .C (c), .PCIN (pcin), .CARRYIN (carryin),
        .P (b_p), .PCOUT (b_pcout), .CARRYOUT (b_co), .CARRYOUTF (b_cof)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [48:0] model_result(input logic [7:0] op, input logic cyi,
                                                 input logic [47:0] pq);
        logic [47:0] x, z;
        case (op[1:0])
            2'd0:    x = 48'd0;
            2'd1:    x = {12'd0, m};
            2'd2:    x = pq;
            default: x = dab;
        endcase
        case (op[3:2])
            2'd0:    z = 48'd0;
            2'd1:    z = pcin;
            2'd2:    z = pq;
            default: z = c;
        endcase
        if (op[7]) return {1'b0, z} - {1'b0, x} - {48'd0, cyi};
        return {1'b0, z} + {1'b0, x} + {48'd0, cyi};
    endfunction

    task automatic tick();
        logic [48:0] r;
        logic [7:0]  op_n;
        logic        cyi_n;
        r     = model_result(m_op, m_cyi, m_p);
        op_n  = ceopmode ? opmode : m_op;
        cyi_n = cecarryin ? carryin : m_cyi;
        @(posedge clk);
        #1;
        m_op  = op_n;
        m_cyi = cyi_n;
        if (cep) {m_co, m_p} = r;
    endtask

    task automatic pulse_rstp();
        rstp = 1'b1;
        #1;
        rstp = 1'b0;
        m_p  = 48'd0;
        m_co = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_p"}, 64'(p), 64'(m_p));
        check_eq({tag, "_pcout"}, 64'(pcout), 64'(m_p));
        check_eq({tag, "_co"}, 64'(carryout), 64'(m_co));
        check_eq({tag, "_cof"}, 64'(carryoutf), 64'(m_co));
    endtask

    initial begin
        rstp = 1'b1; rstcarryin = 1'b1; rstopmode = 1'b1;
        cep = 1'b0; cecarryin = 1'b0; ceopmode = 1'b0;
        opmode = 8'h00; m = '0; dab = '0; c = '0; pcin = '0; carryin = 1'b0;
        m_op = 8'h00; m_cyi = 1'b0; m_p = '0; m_co = 1'b0;
        #12;
        check_eq("rst_p", 64'(p), 64'd0);
        check_eq("rst_pcout", 64'(pcout), 64'd0);
        check_eq("rst_co", 64'(carryout), 64'd0);
        check_eq("rst_cof", 64'(carryoutf), 64'd0);
        rstp = 1'b0; rstcarryin = 1'b0; rstopmode = 1'b0;
        cep = 1'b1; cecarryin = 1'b1; ceopmode = 1'b1;

        // Add: C + M + CARRYIN
        opmode = 8'h0D; m = 36'd5; c = 48'd7; carryin = 1'b1;
        tick(); tick();
        check_eq("add_p", 64'(p), 64'd13);
        check_eq("add_co", 64'(carryout), 64'd0);

        // Subtract with borrow
        opmode = 8'h8D; carryin = 1'b0;
        tick(); tick();
        check_eq("sub_p", 64'(p), 64'd2);
        c = 48'd3;
        tick();
        check_eq("sub_neg_p", 64'(p), 64'hFFFF_FFFF_FFFE);
        check_eq("sub_neg_co", 64'(carryout), 64'd1);

        // Accumulate from zero, then hold with CEP low
        opmode = 8'h09; m = 36'd3;
        tick();
        pulse_rstp();
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq($sformatf("acc_%0d", i), 64'(p), 64'(3 * i));
        end
        cep = 1'b0;
        tick(); check_eq("hold_1", 64'(p), 64'd12);
        tick(); check_eq("hold_2", 64'(p), 64'd12);
        cep = 1'b1;

        // Asynchronous reset mid-accumulation
        pulse_rstp();
        tick(); tick(); tick();
        check_eq("acc_pre_rst", 64'(p), 64'd9);
        #2;
        rstp = 1'b1;
        #1;
        check_eq("async_rst_p", 64'(p), 64'd0);
        check_eq("async_rst_co", 64'(carryout), 64'd0);
        rstp = 1'b0; m_p = '0; m_co = 1'b0;
        tick();
        check_eq("acc_restart", 64'(p), 64'd3);

        // Wrap-around
        opmode = 8'h0F; dab = 48'd1; c = 48'hFFFF_FFFF_FFFF; carryin = 1'b0;
        tick(); tick();
        check_eq("wrap_p", 64'(p), 64'd0);
        check_eq("wrap_co", 64'(carryout), 64'd1);

        // OPMODE change ignored while CEOPMODE is low
        ceopmode = 1'b0; opmode = 8'h0D; m = 36'd5; c = 48'd7;
        tick();
        check_eq("ceop_hold_p", 64'(p), 64'(48'd7 + 48'd1));
        ceopmode = 1'b1;
        tick(); tick();
        check_eq("ceop_take_p", 64'(p), 64'd12);

        // Fully bypassed instance: combinational result, RSTP has no effect
        opmode = 8'h0F; dab = 48'd10; c = 48'd20;
        #1;
        check_eq("byp_p", 64'(b_p), 64'd30);
        check_eq("byp_pcout", 64'(b_pcout), 64'd30);
        rstp = 1'b1;
        #1;
        check_eq("byp_rst_p", 64'(b_p), 64'd30);
        check_eq("byp_rst_co", 64'(b_cof), 64'd0);
        rstp = 1'b0; m_p = '0; m_co = 1'b0;
        opmode = 8'hAF;
        #1;
        check_eq("byp_sub_cin_p", 64'(b_p), 64'd9);
        check_eq("byp_sub_cin_co", 64'(b_co), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            opmode    = 8'($urandom);
            m         = 36'({$urandom, $urandom});
            dab       = 48'({$urandom, $urandom});
            c         = ($urandom_range(0, 7) == 0) ? 48'hFFFF_FFFF_FFFF
                                                    : 48'({$urandom, $urandom});
            pcin      = 48'({$urandom, $urandom});
            carryin   = 1'($urandom);
            cep       = ($urandom_range(0, 3) != 0);
            cecarryin = ($urandom_range(0, 3) != 0);
            ceopmode  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 23))
                0: pulse_rstp();
                1: begin rstcarryin = 1'b1; #1; rstcarryin = 1'b0; m_cyi = 1'b0; end
                2: begin rstopmode = 1'b1; #1; rstopmode = 1'b0; m_op = 8'h00; end
                default: ;
            endcase
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
